seq_stage_controller: RTL

//  Multi-cycle sequencer for the Y86-64 SEQ core: owns the architectural PC and steps

---
 rtl/seq_stage_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: owns the PC,
// steps one stage per clock, selects next PC, stops on halt/faults.
// Ports: clk, reset (sync, active-high), start, fetch/execute/memory
// results (icode, Cnd, valC, valP, valM, mem_error, i_error, halt,
// dmem_error) in; PC, f_en..w_en, busy, stat, retired out.
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             Cnd,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [63:0]      valM,
  input  logic             mem_error,
  input  logic             i_error,
  input  logic             halt,
  input  logic             dmem_error,
  output logic [63:0]      PC,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             busy,
  output logic [2:0]       stat,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_STOP
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t      state;
  logic [3:0]  icode_q;
  logic        cnd_q;
  logic [63:0] valc_q;
  logic [63:0] valp_q;
  logic [63:0] valm_q;
  logic [63:0] next_pc;

  always_comb begin
    next_pc = valp_q;
    case (icode_q)
      4'h7:    next_pc = cnd_q ? valc_q : valp_q;
      4'h8:    next_pc = valc_q;
      4'h9:    next_pc = valm_q;
      default: next_pc = valp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      PC      <= RESET_PC;
      stat    <= STAT_AOK;
      retired <= '0;
      icode_q <= 4'h0;
      cnd_q   <= 1'b0;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      valm_q  <= 64'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          icode_q <= icode;
          valc_q  <= valC;
          valp_q  <= valP;
          // Fault priority: address fault, then bad
          // instruction, then halt.
          if (mem_error) begin
            state <= S_STOP;
            stat  <= STAT_ADR;
          end else if (i_error) begin
            state <= S_STOP;
            stat  <= STAT_INS;
          end else if (halt) begin
            state <= S_STOP;
            stat  <= STAT_HLT;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          cnd_q <= Cnd;
          state <= S_MEMORY;
        end
        S_MEMORY: begin
          valm_q <= valM;
          if (dmem_error) begin
            state <= S_STOP;
            stat  <= STAT_ADR;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          state <= S_PCUPD;
        end
        S_PCUPD: begin
          PC      <= next_pc;
          retired <= retired + ONE;
          state   <= S_FETCH;
        end
        S_STOP: begin
          state <= S_STOP;
        end
      endcase
    end
  end

  assign f_en = (state == S_FETCH);
  assign d_en = (state == S_DECODE);
  assign e_en = (state == S_EXECUTE);
  assign m_en = (state == S_MEMORY);
  assign w_en = (state == S_WRITEBACK);
  assign busy = (state != S_IDLE) && (state != S_STOP);

endmodule
